mojo_avr_uart: RTL and testbench



---
 rtl/mojo_avr_uart.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mojo_avr_uart.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mojo_avr_uart.sv
// 8N1 UART between the FPGA fabric and the Mojo V3 AVR, with busy flow control on TX.
// Define AVR_UART_TX_FIFO_EN for a 4-entry TX FIFO; otherwise a single holding register.
module mojo_avr_uart #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       avr_tx,
    output logic       avr_rx,
    input  logic       avr_rx_busy,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cfg
            $error("mojo_avr_uart: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    // Synchronisers reset to the idle/busy level so nothing moves until real pin values arrive.
    logic [1:0] rx_sync_q;
    logic       rx_prev_q;
    logic [1:0] busy_sync_q;
    logic       rx_line;
    logic       busy_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q   <= 2'b11;
            rx_prev_q   <= 1'b1;
            busy_sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is two stages.
            rx_sync_q   <= {rx_sync_q[0], avr_tx};
            rx_prev_q   <= rx_sync_q[1];
            busy_sync_q <= {busy_sync_q[0], avr_rx_busy};
        end
    end

    assign rx_line = rx_sync_q[1];
    assign busy_s  = busy_sync_q[1];

    logic       tx_push;
    logic       tx_pop;
    logic       buf_empty;
    logic [7:0] buf_data;

    assign tx_push = tx_valid && tx_ready;

`ifdef AVR_UART_TX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (tx_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({tx_push, tx_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign tx_ready  = (count_q < 3'd4);
    assign buf_empty = (count_q == 3'd0);
    assign buf_data  = fifo_mem[rd_ptr_q];
`else
    logic [7:0] hold_q;
    logic       hold_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (tx_push) begin
            hold_q      <= tx_data;
            hold_full_q <= 1'b1;
        end else if (tx_pop) begin
            hold_full_q <= 1'b0;
        end
    end

    assign tx_ready  = !hold_full_q;
    assign buf_empty = !hold_full_q;
    assign buf_data  = hold_q;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_d;
    logic          avr_rx_q;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!buf_empty && !busy_s) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = buf_data;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line_d = 1'b0;
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // The line register lags the state by one cycle, giving the two-edge accept-to-start latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            avr_rx_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            avr_rx_q   <= tx_line_d;
        end
    end

    assign avr_rx = avr_rx_q;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_err_q, rx_err_d;
    logic          rx_bit_end;

    assign rx_bit_end = (rx_cnt_q == BIT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_line) rx_state_d = RX_START;
            end
            RX_START: begin
                // Half a bit in: from here on every sample lands at a bit centre.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rx_line) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_line) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_mojo_avr_uart.sv
// Randomised self-checking bench for mojo_avr_uart; expected line waveforms and bytes come from the 8N1 frame rules.
module tb_mojo_avr_uart;

    localparam int CPB = 100;
`ifdef AVR_UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       avr_tx = 1'b1;
    logic       avr_rx;
    logic       avr_rx_busy = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    mojo_avr_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .avr_tx      (avr_tx),
        .avr_rx      (avr_rx),
        .avr_rx_busy (avr_rx_busy),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts cycles with rx_valid / rx_frame_err high.
    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         valid_cyc = 0;
    logic [7:0] valid_byte = '0;

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            valid_cnt  = valid_cnt + 1;
            valid_cyc  = cyc;
            valid_byte = rx_data;
        end
        if (rst_n && rx_frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line level at cycle i of a frame carrying b: start 0, data LSB first, stop 1.
    function automatic logic frame_level(input logic [7:0] b, input int i);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        return bits[i / CPB];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [7:0] b);
        int k = 0;
        while (!tx_ready && k < 20 * CPB) begin
            @(negedge clk);
            k++;
        end
        check("push_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic try_push(input logic [7:0] b, output int ok);
        ok = int'(tx_ready);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Counts posedges until avr_rx is seen low at a negedge, up to limit.
    task automatic wait_start(input int limit, output int k);
        k = 0;
        while (avr_rx && k < limit) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    // Starts at the first negedge where the start bit is visible.
    task automatic capture(input logic [7:0] exp, input string tag);
        int         bad = 0;
        logic [7:0] got = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (avr_rx !== frame_level(exp, i)) bad++;
            if (i >= CPB && i < 9 * CPB && (i % CPB) == CPB / 2) got[i / CPB - 1] = avr_rx;
            @(negedge clk);
        end
        check({tag, "_byte"}, got, exp);
        check({tag, "_bad_cycles"}, bad, 0);
        check({tag, "_line_after"}, avr_rx, 1);
    endtask

    task automatic frame(input logic [7:0] exp, input string tag);
        int k;
        wait_start(30 * CPB, k);
        check({tag, "_start_seen"}, k < 30 * CPB, 1);
        if (k < 30 * CPB) capture(exp, tag);
    endtask

    task automatic count_lows(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (avr_rx !== 1'b1) lows++;
        end
    endtask

    // Drives one 8N1 frame on avr_tx (stop level selectable), then one idle bit.
    task automatic drive_rx(input logic [7:0] b, input logic stop, output int c0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            avr_tx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        avr_tx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int         k, lows, c0, t0, ok, acc, v0, e0;
        logic [7:0] last_good;
        logic [7:0] tx_q [6];
        logic [7:0] rb;
        logic       stop;

        repeat (3) @(negedge clk);
        check("rst_avr_rx", avr_rx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_err", rx_frame_err, 0);
        check("rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_avr_rx", avr_rx, 1);

        // Single byte: latency from accept edge and exact waveform.
        push(8'hA5);
        wait_start(10, k);
        check("tx_latency_edges", k, 2);
        capture(8'hA5, "tx_a5");

        // Busy flow control.
        avr_rx_busy = 1'b1;
        repeat (4) @(negedge clk);
        push(8'h3C);
        count_lows(3 * CPB, lows);
        check("busy_hold_lows", lows, 0);
        avr_rx_busy = 1'b0;
        wait_start(20, k);
        check("busy_release_3to4", (k >= 3 && k <= 4), 1);
        fork
            capture(8'h3C, "busy_midframe");
            begin
                repeat (300) @(negedge clk);
                avr_rx_busy = 1'b1;
            end
        join
        push(8'hC3);
        count_lows(3 * CPB, lows);
        check("busy_blocks_next_lows", lows, 0);
        avr_rx_busy = 1'b0;
        frame(8'hC3, "busy_next");

        // Random back-to-back bytes; second byte accepted while the first frame runs.
        for (int i = 0; i < 6; i++) tx_q[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 6; i++) frame(tx_q[i], $sformatf("rand_tx%0d", i));
            end
            begin
                push(tx_q[0]);
                t0 = cyc;
                push(tx_q[1]);
                check("second_accept_delay_le2", (cyc - t0) <= 2, 1);
                for (int i = 2; i < 6; i++) push(tx_q[i]);
            end
        join

        // RX: good byte, latency and data.
        v0 = valid_cnt;
        e0 = err_cnt;
        drive_rx(8'h5A, 1'b1, c0);
        last_good = 8'h5A;
        check("rx5a_pulses", valid_cnt - v0, 1);
        check("rx5a_data", valid_byte, 8'h5A);
        check("rx5a_latency_952_954", (valid_cyc - c0 >= 952) && (valid_cyc - c0 <= 954), 1);
        check("rx5a_no_err", err_cnt - e0, 0);

        // Stop-bit error, then recovery.
        v0 = valid_cnt;
        e0 = err_cnt;
        drive_rx(8'hFF, 1'b0, c0);
        check("rxff_err_pulses", err_cnt - e0, 1);
        check("rxff_no_valid", valid_cnt - v0, 0);
        check("rxff_data_held", rx_data, last_good);
        drive_rx(8'h01, 1'b1, c0);
        last_good = 8'h01;
        check("rx01_pulses", valid_cnt - v0, 1);
        check("rx01_data", rx_data, 8'h01);

        // 20-cycle glitch yields nothing and RX still works afterwards.
        v0 = valid_cnt;
        e0 = err_cnt;
        avr_tx = 1'b0;
        repeat (20) @(negedge clk);
        avr_tx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_err", err_cnt - e0, 0);

        // Random RX bytes, occasional bad stop bit.
        for (int i = 0; i < 7; i++) begin
            rb   = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            v0   = valid_cnt;
            e0   = err_cnt;
            drive_rx(rb, stop, c0);
            if (stop) last_good = rb;
            check($sformatf("rand_rx%0d_valid", i), valid_cnt - v0, int'(stop));
            check($sformatf("rand_rx%0d_err", i), err_cnt - e0, int'(!stop));
            check($sformatf("rand_rx%0d_data", i), rx_data, last_good);
        end

        // Buffer depth under busy, then reset mid-frame.
        avr_rx_busy = 1'b1;
        repeat (4) @(negedge clk);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            try_push(8'(8'h10 + i), ok);
            acc += ok;
        end
        check("busy_accepted", acc, DEPTH);
        check("busy_full_ready", tx_ready, 0);
        avr_rx_busy = 1'b0;
        wait_start(20, k);
        check("pre_reset_start_seen", k < 20, 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_avr_rx", avr_rx, 1);
        check("async_rst_tx_ready", tx_ready, 1);
        check("async_rst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_tx_ready", tx_ready, 1);
        count_lows(12 * CPB, lows);
        check("after_rst_no_frames", lows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
